// File: rtl/plab4_net_domain_sched.sv
// plab4_net_domain_sched: fixed D0 / DEAD0 / D1 / DEAD1 time-division schedule for the ring enables.
// Define PLAB4_NET_DOMAIN_SCHED_CFG_EN to allow runtime window lengths, applied at period boundaries.
module plab4_net_domain_sched #(
  parameter int p_cnt_nbits   = 8,
  parameter int p_d0_cycles   = 8,
  parameter int p_d1_cycles   = 8,
  parameter int p_dead_cycles = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  output logic                   domain0_o,
  output logic                   domain1_o,
  output logic                   epoch_start_o,
  output logic [2:0]             cur_phase_o,
  input  logic                   cfg_val_i,
  output logic                   cfg_rdy_o,
  input  logic [p_cnt_nbits-1:0] cfg_d0_len_i,
  input  logic [p_cnt_nbits-1:0] cfg_d1_len_i
);
  localparam int W = p_cnt_nbits;
  localparam logic [W-1:0] D0_INIT   = W'(p_d0_cycles);
  localparam logic [W-1:0] D1_INIT   = W'(p_d1_cycles);
  localparam logic [W-1:0] DEAD_LEN  = W'(p_dead_cycles);
  localparam logic [W-1:0] ONE       = W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D0    = 3'd1,
    DEAD0 = 3'd2,
    D1    = 3'd3,
    DEAD1 = 3'd4
  } phase_e;

  phase_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           dom0_q, dom1_q, epoch_q, epoch_d;
  logic [W-1:0]   act_d0_q, act_d1_q, sh_d0_q, sh_d1_q;
  logic           pend_q;
  logic           start, found, apply;
  logic [W-1:0]   eff_d0, eff_d1;
  logic [4:1][W-1:0] len_cur, len_new;

  // A new period uses any pending lengths; the running period keeps the active ones.
  assign eff_d0 = pend_q ? sh_d0_q : act_d0_q;
  assign eff_d1 = pend_q ? sh_d1_q : act_d1_q;

  always_comb begin
    len_cur = {DEAD_LEN, act_d1_q, DEAD_LEN, act_d0_q};
    len_new = {DEAD_LEN, eff_d1,   DEAD_LEN, eff_d0};
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    found   = 1'b0;
    apply   = 1'b0;
    epoch_d = 1'b0;
    if (state_q == IDLE) begin
      start = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end else begin
      for (int p = 1; p <= 4; p++) begin
        if (!found && (p > int'(state_q)) && (len_cur[p] != '0)) begin
          found   = 1'b1;
          state_d = phase_e'(p[2:0]);
          cnt_d   = len_cur[p] - ONE;
        end
      end
      start = !found;
    end
    // Period boundary: en is only sampled here so a period is never cut short.
    if (start) begin
      state_d = IDLE;
      cnt_d   = '0;
      found   = 1'b0;
      if (en_i) begin
        apply = pend_q;
        for (int p = 1; p <= 4; p++) begin
          if (!found && (len_new[p] != '0)) begin
            found   = 1'b1;
            state_d = phase_e'(p[2:0]);
            cnt_d   = len_new[p] - ONE;
          end
        end
        epoch_d = found;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dom0_q  <= 1'b0;
      dom1_q  <= 1'b0;
      epoch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dom0_q  <= (state_d == D0);
      dom1_q  <= (state_d == D1);
      epoch_q <= epoch_d;
    end
  end

  assign domain0_o     = dom0_q;
  assign domain1_o     = dom1_q;
  assign epoch_start_o = epoch_q;
  assign cur_phase_o   = state_q;

`ifdef PLAB4_NET_DOMAIN_SCHED_CFG_EN
  logic rdy_q, accept;
  assign accept = cfg_val_i & rdy_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      act_d0_q <= D0_INIT;
      act_d1_q <= D1_INIT;
      sh_d0_q  <= '0;
      sh_d1_q  <= '0;
      pend_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      if (apply) begin
        act_d0_q <= sh_d0_q;
        act_d1_q <= sh_d1_q;
      end
      if (accept) begin
        sh_d0_q <= cfg_d0_len_i;
        sh_d1_q <= cfg_d1_len_i;
      end
      pend_q <= accept | (pend_q & ~apply);
      // Ready drops on accept and comes back the cycle after the apply edge.
      rdy_q  <= ~pend_q & ~accept;
    end
  end

  assign cfg_rdy_o = rdy_q;
`else
  logic cfg_unused;
  assign act_d0_q   = D0_INIT;
  assign act_d1_q   = D1_INIT;
  assign sh_d0_q    = D0_INIT;
  assign sh_d1_q    = D1_INIT;
  assign pend_q     = 1'b0;
  assign cfg_rdy_o  = 1'b0;
  assign cfg_unused = ^{cfg_val_i, cfg_d0_len_i, cfg_d1_len_i, apply};
`endif

endmodule

// File: tb/tb_plab4_net_domain_sched.sv
// Scoreboard bench for plab4_net_domain_sched: two instances (4/3/2 and 0/5/1) against a
// period-offset reference model; stimulus pushes expectations, a negedge monitor checks them.
module tb_plab4_net_domain_sched;
`ifdef PLAB4_NET_DOMAIN_SCHED_CFG_EN
  localparam bit CFG_ON = 1'b1;
`else
  localparam bit CFG_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, cfg_val;
  logic [7:0] cfg_d0, cfg_d1;
  logic       a_d0, a_d1, a_ep, a_rdy, b_d0, b_d1, b_ep, b_rdy;
  logic [2:0] a_ph, b_ph;

  always #5 clk = ~clk;

  plab4_net_domain_sched #(.p_cnt_nbits(8), .p_d0_cycles(4), .p_d1_cycles(3), .p_dead_cycles(2)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .domain0_o(a_d0), .domain1_o(a_d1),
    .epoch_start_o(a_ep), .cur_phase_o(a_ph), .cfg_val_i(cfg_val), .cfg_rdy_o(a_rdy),
    .cfg_d0_len_i(cfg_d0), .cfg_d1_len_i(cfg_d1));

  plab4_net_domain_sched #(.p_cnt_nbits(8), .p_d0_cycles(0), .p_d1_cycles(5), .p_dead_cycles(1)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .domain0_o(b_d0), .domain1_o(b_d1),
    .epoch_start_o(b_ep), .cur_phase_o(b_ph), .cfg_val_i(cfg_val), .cfg_rdy_o(b_rdy),
    .cfg_d0_len_i(cfg_d0), .cfg_d1_len_i(cfg_d1));

  typedef struct packed {
    logic [2:0] ph;
    logic       d0;
    logic       d1;
    logic       ep;
    logic       rdy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   started = 1'b0;

  // Reference model: per instance, whether a period runs and the offset into it.
  int P_D0[2]   = '{4, 0};
  int P_D1[2]   = '{3, 5};
  int P_DEAD[2] = '{2, 1};
  int m_d0[2], m_d1[2], m_t[2], m_sh0[2], m_sh1[2];
  bit m_run[2], m_pend[2], m_rdy[2];

  function automatic exp_t model_out(int i);
    exp_t e;
    int   t;
    e = '0;
    if (m_run[i]) begin
      t = m_t[i];
      if (t < m_d0[i])                              e.ph = 3'd1;
      else if (t < m_d0[i] + P_DEAD[i])             e.ph = 3'd2;
      else if (t < m_d0[i] + P_DEAD[i] + m_d1[i])   e.ph = 3'd3;
      else                                          e.ph = 3'd4;
      e.ep = (t == 0);
    end
    e.d0  = (e.ph == 3'd1);
    e.d1  = (e.ph == 3'd3);
    e.rdy = m_rdy[i];
    return e;
  endfunction

  task automatic model_reset(int i);
    m_d0[i] = P_D0[i]; m_d1[i] = P_D1[i];
    m_sh0[i] = 0; m_sh1[i] = 0;
    m_run[i] = 1'b0; m_t[i] = 0; m_pend[i] = 1'b0; m_rdy[i] = 1'b0;
  endtask

  task automatic model_step(int i, bit en_s, bit val_s, int c0, int c1);
    bit accept, pend_old;
    accept   = CFG_ON && val_s && m_rdy[i];
    pend_old = m_pend[i];
    if (m_run[i] && (m_t[i] + 1 < m_d0[i] + m_d1[i] + 2 * P_DEAD[i])) begin
      m_t[i]++;
    end else begin
      m_run[i] = 1'b0;
      if (en_s) begin
        if (m_pend[i]) begin
          m_d0[i] = m_sh0[i]; m_d1[i] = m_sh1[i]; m_pend[i] = 1'b0;
        end
        if (m_d0[i] + m_d1[i] + 2 * P_DEAD[i] > 0) begin
          m_run[i] = 1'b1; m_t[i] = 0;
        end
      end
    end
    if (accept) begin
      m_sh0[i] = c0; m_sh1[i] = c1; m_pend[i] = 1'b1;
    end
    m_rdy[i] = CFG_ON && !pend_old && !accept;
  endtask

  // One clock: the model consumes the inputs that were present at the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) model_reset(i);
      else        model_step(i, en, cfg_val, int'(cfg_d0), int'(cfg_d1));
    end
    q_a.push_back(model_out(0));
    q_b.push_back(model_out(1));
    started = 1'b1;
  endtask

  task automatic cmp(input string nm, input exp_t act, input exp_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got ph=%0d d0=%b d1=%b ep=%b rdy=%b, want ph=%0d d0=%b d1=%b ep=%b rdy=%b",
                  nm, $time, act.ph, act.d0, act.d1, act.ep, act.rdy,
                  exp.ph, exp.d0, exp.d1, exp.ep, exp.rdy);
  endtask

  exp_t ea, eb;
  always @(negedge clk) begin
    if (started) begin
      n_total++;
      if (!(a_d0 && a_d1) && !(b_d0 && b_d1)) n_pass++;
      else $display("FAIL excl: a_d0=%b a_d1=%b b_d0=%b b_d1=%b, want never both 1", a_d0, a_d1, b_d0, b_d1);
      if (q_a.size() == 0 || q_b.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: q_a=%0d q_b=%0d entries, want >=1 each", q_a.size(), q_b.size());
      end else begin
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        cmp("dut_a", {a_ph, a_d0, a_d1, a_ep, a_rdy}, ea);
        cmp("dut_b", {b_ph, b_d0, b_d1, b_ep, b_rdy}, eb);
      end
    end
  end

  int waited;

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_val = 1'b0; cfg_d0 = '0; cfg_d1 = '0;
    model_reset(0); model_reset(1);
    tick();
    tick();
    #2 rst_n = 1'b1; en = 1'b1;
    repeat (60) tick();

    // Async reset in the second D1 cycle of dut_a.
    waited = 0;
    do begin tick(); waited++; end
    while (!(m_run[0] && m_t[0] == m_d0[0] + P_DEAD[0] + 1) && waited < 50);
    if (waited >= 50) begin
      n_total++;
      $display("FAIL wait_d1: waited %0d cycles, want D1 cycle 2 within 50", waited);
    end
    #2 rst_n = 1'b0;
    void'(q_a.pop_back()); void'(q_b.pop_back());
    model_reset(0); model_reset(1);
    q_a.push_back(model_out(0)); q_b.push_back(model_out(1));
    #1;
    n_total++;
    if (a_d1 === 1'b0 && a_d0 === 1'b0 && a_ep === 1'b0) n_pass++;
    else $display("FAIL async_reset: d0=%b d1=%b ep=%b, want 0 0 0", a_d0, a_d1, a_ep);
    tick();
    #2 rst_n = 1'b1; en = 1'b1;
    repeat (40) tick();

    // Random en toggling and random configuration requests.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 39) == 0) en = ~en;
      cfg_val = ($urandom_range(0, 9) == 0);
      cfg_d0  = 8'($urandom_range(0, 7));
      cfg_d1  = 8'($urandom_range(0, 7));
    end

    // Directed: request 6/2 while dut_a is in D1, held for a while.
    en = 1'b1; cfg_val = 1'b0;
    waited = 0;
    do begin tick(); waited++; end
    while (!(m_run[0] && m_t[0] >= m_d0[0] + P_DEAD[0] && m_t[0] < m_d0[0] + P_DEAD[0] + m_d1[0]) && waited < 200);
    if (waited >= 200) begin
      n_total++;
      $display("FAIL wait_cfg_d1: waited %0d cycles, want D1 within 200", waited);
    end
    cfg_val = 1'b1; cfg_d0 = 8'd6; cfg_d1 = 8'd2;
    repeat (30) tick();
    cfg_val = 1'b0;
    repeat (60) tick();
    en = 1'b0;
    repeat (40) tick();

    @(negedge clk);
    #1;
    started = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
